// File: rtl/sram_bridge.sv
// RISC5 data-bus responder: runs core loads/stores on a 512K x 16 asynchronous SRAM in one or two
// half-word phases, stalls the core meanwhile, and passes the top 64-byte I/O window through.
module sram_bridge #(
  parameter int unsigned WAIT_CYC = 1,
  parameter logic [13:0] IO_TOP   = 14'h3FFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] adr,
  input  logic        rd,
  input  logic        wr,
  input  logic        ben,
  input  logic [31:0] outbus,
  output logic [31:0] inbus,
  output logic        stallX,
  output logic        io_sel,
  input  logic [31:0] io_din,
  output logic [18:0] sram_adr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StDone} state_e;

  state_e        state_q;
  logic          phase_q;
  logic [CW-1:0] cnt_q;
  logic          hit_v_q;
  logic [19:0]   adr_q;
  logic          ben_q;
  logic          wr_q;
  logic [31:0]   wdat_q;
  logic [31:0]   data_q;

  logic        req, hit, accept, last, more, go_setup, phase_n;
  logic [19:0] c_adr;
  logic        c_ben, c_wr;
  logic [31:0] c_dat;
  logic [18:0] su_adr;
  logic [15:0] su_dout;
  logic        su_ub_n, su_lb_n;

  assign io_sel = (adr[19:6] == IO_TOP);
  assign inbus  = io_sel ? io_din : data_q;

  always_comb begin
    req      = (rd | wr) & ~io_sel;
    hit      = (state_q == StDone) & hit_v_q & req & (adr == adr_q) & (ben == ben_q) &
               (wr == wr_q);
    accept   = req & ((state_q == StIdle) | ((state_q == StDone) & ~hit));
    last     = (cnt_q == CNT_LAST);
    more     = ~ben_q & ~phase_q;
    go_setup = accept | ((state_q == StAccess) & last & more);
    // A setup entered from ACCESS is always the second half-word phase.
    phase_n  = (state_q == StAccess);
    c_adr    = accept ? adr : adr_q;
    c_ben    = accept ? ben : ben_q;
    c_wr     = accept ? wr : wr_q;
    c_dat    = accept ? outbus : wdat_q;
    su_adr   = c_ben ? c_adr[19:1] : {c_adr[19:2], phase_n};
    su_dout  = c_ben ? {2{c_dat[7:0]}} : (phase_n ? c_dat[31:16] : c_dat[15:0]);
    su_ub_n  = c_ben & ~c_adr[0];
    su_lb_n  = c_ben & c_adr[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      phase_q   <= 1'b0;
      cnt_q     <= '0;
      hit_v_q   <= 1'b0;
      adr_q     <= '0;
      ben_q     <= 1'b0;
      wr_q      <= 1'b0;
      wdat_q    <= '0;
      data_q    <= '0;
      stallX    <= 1'b0;
      sram_adr  <= '0;
      sram_dout <= '0;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ce_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_q <= StSetup;
        end
        StSetup: begin
          state_q   <= StAccess;
          cnt_q     <= '0;
          sram_we_n <= ~wr_q;
        end
        StAccess: begin
          if (last) begin
            sram_we_n <= 1'b1;
            if (!wr_q) begin
              if (ben_q) data_q <= {24'h0, adr_q[0] ? sram_din[15:8] : sram_din[7:0]};
              else if (phase_q) data_q[31:16] <= sram_din;
              else data_q[15:0] <= sram_din;
            end
            if (more) begin
              state_q <= StSetup;
              phase_q <= 1'b1;
            end else begin
              state_q   <= StDone;
              stallX    <= 1'b0;
              sram_ce_n <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_ub_n <= 1'b1;
              sram_lb_n <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          hit_v_q <= 1'b0;
          state_q <= accept ? StSetup : StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (accept) begin
        adr_q   <= adr;
        ben_q   <= ben;
        wr_q    <= wr;
        wdat_q  <= outbus;
        hit_v_q <= 1'b1;
        phase_q <= 1'b0;
      end

      if (go_setup) begin
        stallX    <= 1'b1;
        sram_adr  <= su_adr;
        sram_dout <= su_dout;
        sram_ce_n <= 1'b0;
        sram_oe_n <= c_wr;
        sram_we_n <= 1'b1;
        sram_ub_n <= su_ub_n;
        sram_lb_n <= su_lb_n;
      end
    end
  end

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: one task per scenario, two instances (WAIT_CYC=1 and 3).
module tb_sram_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [19:0] adr;
  logic        rd, wr, ben;
  logic [31:0] outbus, io_din, inbus;
  logic        stallX, io_sel;
  logic [18:0] sram_adr;
  logic [15:0] sram_dout, sram_din;
  logic        oe_n, we_n, ce_n, ub_n, lb_n;

  logic [19:0] adr3;
  logic        rd3;
  logic [31:0] inbus3;
  logic        stallX3, io_sel3;
  logic [18:0] sram_adr3;
  logic [15:0] sram_dout3, din3;
  logic        oe_n3, we_n3, ce_n3, ub_n3, lb_n3;

  sram_bridge #(.WAIT_CYC(1)) dut (
    .clk(clk), .rst(rst), .adr(adr), .rd(rd), .wr(wr), .ben(ben), .outbus(outbus),
    .inbus(inbus), .stallX(stallX), .io_sel(io_sel), .io_din(io_din),
    .sram_adr(sram_adr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_oe_n(oe_n), .sram_we_n(we_n), .sram_ce_n(ce_n), .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  sram_bridge #(.WAIT_CYC(3)) dut3 (
    .clk(clk), .rst(rst), .adr(adr3), .rd(rd3), .wr(1'b0), .ben(1'b0), .outbus(32'h0),
    .inbus(inbus3), .stallX(stallX3), .io_sel(io_sel3), .io_din(32'h0),
    .sram_adr(sram_adr3), .sram_dout(sram_dout3), .sram_din(din3),
    .sram_oe_n(oe_n3), .sram_we_n(we_n3), .sram_ce_n(ce_n3), .sram_ub_n(ub_n3),
    .sram_lb_n(lb_n3)
  );

  // Small SRAM model for the WAIT_CYC=1 instance, honouring byte lanes.
  logic [15:0] mem [256];
  int we_cycles = 0;
  int ce_cycles = 0;
  assign sram_din = (!ce_n && !oe_n) ? mem[sram_adr[7:0]] : 16'hF00F;

  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[sram_adr[7:0]][15:8] <= sram_dout[15:8];
      if (!lb_n) mem[sram_adr[7:0]][7:0] <= sram_dout[7:0];
      we_cycles <= we_cycles + 1;
    end
    if (!ce_n) ce_cycles <= ce_cycles + 1;
  end

  int checks = 0;
  int passed = 0;

  task automatic do_access(input logic r, input logic w, input logic b, input logic [19:0] a,
                           input logic [31:0] d, input bit replay, output int nstall,
                           output logic [31:0] rdat, output logic [18:0] s_adr,
                           output logic s_ub_n, output logic s_lb_n, output logic [15:0] s_dout);
    @(posedge clk); #1;
    rd = r; wr = w; ben = b; adr = a; outbus = d;
    nstall = 0;
    s_adr = '0; s_ub_n = 1'b1; s_lb_n = 1'b1; s_dout = '0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallX) begin
        if (nstall == 0) begin
          s_adr = sram_adr; s_ub_n = ub_n; s_lb_n = lb_n; s_dout = sram_dout;
        end
        nstall++;
      end else begin
        break;
      end
    end
    rdat = inbus;
    if (replay) begin
      @(posedge clk); #1;
      rd = 1'b0; wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (stallX !== 1'b0) $display("FAIL reset_stall: got %b want 0", stallX); else passed++;
    checks++; if ({ce_n, oe_n, we_n, ub_n, lb_n} !== 5'b11111)
      $display("FAIL reset_strobes: got %b want 11111", {ce_n, oe_n, we_n, ub_n, lb_n});
    else passed++;
    checks++; if (sram_adr !== 19'h0) $display("FAIL reset_adr: got %h want 0", sram_adr);
    else passed++;
    checks++; if (sram_dout !== 16'h0) $display("FAIL reset_dout: got %h want 0", sram_dout);
    else passed++;
    checks++; if (inbus !== 32'h0) $display("FAIL reset_inbus: got %h want 0", inbus);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_word();
    int n, ce0, we0;
    logic [31:0] rdat;
    logic [18:0] sa;
    logic sub, slb;
    logic [15:0] sd;
    ce0 = ce_cycles; we0 = we_cycles;
    do_access(1'b0, 1'b1, 1'b0, 20'h00100, 32'hDEADBEEF, 1'b1, n, rdat, sa, sub, slb, sd);
    repeat (2) @(negedge clk);
    checks++; if (n != 4) $display("FAIL word_wr_stall: got %0d want 4", n); else passed++;
    checks++; if (sa !== 19'h00080 || sub !== 1'b0 || slb !== 1'b0 || sd !== 16'hBEEF)
      $display("FAIL word_wr_setup: got adr %h ub %b lb %b dout %h want 00080 0 0 beef",
               sa, sub, slb, sd);
    else passed++;
    checks++; if (mem[8'h80] !== 16'hBEEF || mem[8'h81] !== 16'hDEAD)
      $display("FAIL word_wr_mem: got %h %h want beef dead", mem[8'h80], mem[8'h81]);
    else passed++;
    checks++; if (we_cycles - we0 != 2) $display("FAIL word_wr_we: got %0d want 2", we_cycles - we0);
    else passed++;
    checks++; if (ce_cycles - ce0 != 4) $display("FAIL word_wr_ce: got %0d want 4", ce_cycles - ce0);
    else passed++;

    ce0 = ce_cycles; we0 = we_cycles;
    do_access(1'b1, 1'b0, 1'b0, 20'h00100, 32'h0, 1'b1, n, rdat, sa, sub, slb, sd);
    repeat (2) @(negedge clk);
    checks++; if (n != 4) $display("FAIL word_rd_stall: got %0d want 4", n); else passed++;
    checks++; if (rdat !== 32'hDEADBEEF) $display("FAIL word_rd_data: got %h want deadbeef", rdat);
    else passed++;
    checks++; if (ce_cycles - ce0 != 4 || we_cycles != we0)
      $display("FAIL word_rd_replay: got ce %0d we %0d want 4 0", ce_cycles - ce0, we_cycles - we0);
    else passed++;
  endtask

  task automatic test_byte();
    int n;
    logic [31:0] rdat;
    logic [18:0] sa;
    logic sub, slb;
    logic [15:0] sd;
    do_access(1'b0, 1'b1, 1'b1, 20'h00103, 32'h0000005A, 1'b1, n, rdat, sa, sub, slb, sd);
    checks++; if (n != 2) $display("FAIL byte_wr_stall: got %0d want 2", n); else passed++;
    checks++; if (sa !== 19'h00081 || sub !== 1'b0 || slb !== 1'b1 || sd !== 16'h5A5A)
      $display("FAIL byte_wr_setup: got adr %h ub %b lb %b dout %h want 00081 0 1 5a5a",
               sa, sub, slb, sd);
    else passed++;
    checks++; if (mem[8'h81] !== 16'h5AAD) $display("FAIL byte_wr_mem: got %h want 5aad", mem[8'h81]);
    else passed++;
    do_access(1'b1, 1'b0, 1'b1, 20'h00103, 32'h0, 1'b1, n, rdat, sa, sub, slb, sd);
    checks++; if (n != 2) $display("FAIL byte_rd_stall: got %0d want 2", n); else passed++;
    checks++; if (rdat !== 32'h0000005A) $display("FAIL byte_rd_data: got %h want 0000005a", rdat);
    else passed++;
  endtask

  task automatic test_io();
    int bad;
    @(posedge clk); #1;
    rd = 1'b1; adr = 20'hFFFC4; io_din = 32'h12345678; ben = 1'b0;
    @(negedge clk);
    checks++; if (io_sel !== 1'b1) $display("FAIL io_sel: got %b want 1", io_sel); else passed++;
    checks++; if (inbus !== 32'h12345678) $display("FAIL io_data: got %h want 12345678", inbus);
    else passed++;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (stallX !== 1'b0 || ce_n !== 1'b1) bad++;
    end
    checks++; if (bad != 0) $display("FAIL io_quiet: got %0d active cycles want 0", bad);
    else passed++;
    @(posedge clk); #1;
    rd = 1'b0; io_din = 32'h0;
  endtask

  task automatic test_mismatch();
    int n;
    logic [31:0] rdat;
    logic [18:0] sa;
    logic sub, slb;
    logic [15:0] sd;
    do_access(1'b1, 1'b0, 1'b0, 20'h00100, 32'h0, 1'b0, n, rdat, sa, sub, slb, sd);
    checks++; if (rdat !== 32'h5AADBEEF) $display("FAIL mm_first: got %h want 5aadbeef", rdat);
    else passed++;
    adr = 20'h00104;
    @(negedge clk);
    checks++; if (stallX !== 1'b1 || ce_n !== 1'b0 || sram_adr !== 19'h00082)
      $display("FAIL mm_restart: got stall %b ce_n %b adr %h want 1 0 00082",
               stallX, ce_n, sram_adr);
    else passed++;
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallX) n++;
      else break;
    end
    checks++; if (n != 4) $display("FAIL mm_stall: got %0d want 4", n); else passed++;
    checks++; if (inbus !== 32'h01830182) $display("FAIL mm_data: got %h want 01830182", inbus);
    else passed++;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int we0, n;
    @(posedge clk); #1;
    wr = 1'b1; rd = 1'b0; ben = 1'b0; adr = 20'h00108; outbus = 32'hCAFEF00D;
    we0 = we_cycles;
    repeat (3) @(negedge clk);
    checks++; if (we_n !== 1'b0) $display("FAIL rmw_we_active: got %b want 0", we_n); else passed++;
    #1 rst = 1'b0;
    #1;
    checks++; if (we_n !== 1'b1 || ce_n !== 1'b1 || stallX !== 1'b0)
      $display("FAIL rmw_abort: got we_n %b ce_n %b stall %b want 1 1 0", we_n, ce_n, stallX);
    else passed++;
    @(posedge clk); #3 rst = 1'b1;
    @(negedge clk);
    checks++; if (stallX !== 1'b0 || we_cycles != we0)
      $display("FAIL rmw_idle: got stall %b we %0d want 0 0", stallX, we_cycles - we0);
    else passed++;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (stallX) n++;
      else break;
    end
    @(posedge clk); #1;
    wr = 1'b0;
    checks++; if (n != 4) $display("FAIL rmw_fresh_stall: got %0d want 4", n); else passed++;
    checks++; if (mem[8'h84] !== 16'hF00D || mem[8'h85] !== 16'hCAFE || we_cycles - we0 != 2)
      $display("FAIL rmw_fresh_mem: got %h %h we %0d want f00d cafe 2",
               mem[8'h84], mem[8'h85], we_cycles - we0);
    else passed++;
  endtask

  task automatic test_wait3();
    int n, bad;
    @(posedge clk); #1;
    rd3 = 1'b1; adr3 = 20'h00200; din3 = 16'h1000;
    n = 0; bad = 0;
    @(negedge clk);
    for (int k = 1; k < 20; k++) begin
      @(posedge clk); #1;
      din3 = 16'h1000 + 16'(k);
      @(negedge clk);
      if (we_n3 !== 1'b1) bad++;
      if (stallX3) n++;
      else break;
    end
    checks++; if (n != 8) $display("FAIL w3_stall: got %0d want 8", n); else passed++;
    checks++; if (bad != 0) $display("FAIL w3_we: got %0d low cycles want 0", bad); else passed++;
    checks++; if (inbus3 !== 32'h10081004) $display("FAIL w3_data: got %h want 10081004", inbus3);
    else passed++;
    @(posedge clk); #1;
    rd3 = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0100 + 16'(i);
    rst = 1'b1;
    adr = '0; rd = 1'b0; wr = 1'b0; ben = 1'b0; outbus = '0; io_din = '0;
    adr3 = '0; rd3 = 1'b0; din3 = '0;
    #3 rst = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_io();
    test_mismatch();
    test_reset_mid_write();
    test_wait3();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sram_bridge.md
Name: sram_bridge

Overview:
- CPU-side memory responder for the RISC5 data bus.
- Accepts the core's byte/word load/store requests (adr, rd, wr, ben, outbus) and runs them on an external 512K x 16 asynchronous SRAM as one or two half-word phases.
- Stalls the core through stallX and returns load data on inbus.
- Passes the top 64-byte I/O window straight through to the I/O fabric with no stall.

Parameters:
- WAIT_CYC, 1: access cycles per SRAM phase (≥1); WE low / read-sample window length.
- IO_TOP, 14'h3FFF: value of adr[19:6] that selects the I/O window.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low
- adr  in  20  byte address from core
- rd  in  1  load strobe
- wr  in  1  store strobe
- ben  in  1  byte access (1) / word access (0)
- outbus  in  32  store data from core
- inbus  out  32  load data to core
- stallX  out  1  stall request to core, registered
- io_sel  out  1  adr in I/O window (combinational)
- io_din  in  32  I/O read data
- sram_adr  out  19  half-word address
- sram_dout  out  16  write data
- sram_din  in  16  read data
- sram_oe_n  out  1  output enable
- sram_we_n  out  1  write enable
- sram_ce_n  out  1  chip enable
- sram_ub_n  out  1  upper-byte enable
- sram_lb_n  out  1  lower-byte enable

Behaviour:
- Reset (rst=0, async):
  - State goes to IDLE; hit-valid cleared; data register cleared.
  - stallX=0.
  - sram_ce_n=sram_oe_n=sram_we_n=sram_ub_n=sram_lb_n=1; sram_adr=0; sram_dout=0.
  - Reset mid-access abandons the access immediately: any write phase in progress ends with we_n=1 the same instant.
- I/O window:
  - io_sel = (adr[19:6]==IO_TOP).
  - When io_sel=1, inbus=io_din, no stall, no SRAM activity.
- Request acceptance:
  - In IDLE, rd|wr with io_sel=0 and no hit: latch adr, ben, rd/wr and outbus; set hit-valid; go to SETUP (phase 0). stallX=1 from the next cycle.
  - rd and wr both high: treat as wr.
- Phase mapping:
  - Word access:
    - Phase 0: sram_adr={adr[19:2],0}, ub=lb=enabled, bits 15:0.
    - Phase 1: sram_adr={adr[19:2],1}, bits 31:16.
  - Byte access:
    - Single phase: sram_adr=adr[19:1].
    - lb enabled iff adr[0]=0; ub enabled iff adr[0]=1.
    - Write data = {outbus[7:0],outbus[7:0]}.
    - Read returns the selected byte zero-extended into inbus[7:0].
- State machine: IDLE -> SETUP -> ACCESS -> (SETUP for phase 1 | DONE) -> IDLE.
  - SETUP: 1 cycle.
    - ce_n=0 with address and ub/lb stable.
    - Read: oe_n=0. Write: oe_n=1, dout driven, we_n=1.
  - ACCESS: WAIT_CYC cycles.
    - Write: we_n=0 throughout.
    - Read: sram_din captured into the data register half on the last cycle.
  - DONE: 1 cycle.
    - stallX=0; inbus = data register.
    - All SRAM strobes deasserted.
- Word read latency (WAIT_CYC=1), request in cycle N:
  - stallX high N+1..N+4.
  - DONE at N+5.
  - General rule: stallX high for phases*(1+WAIT_CYC) cycles.
- Replay rule:
  - The core reissues the stalled access when stallX falls.
  - In DONE, rd|wr with adr, ben and direction equal to the latched values is a hit. The hit completes without a new SRAM cycle: read data is returned combinationally on inbus, and writes are not repeated. Hit-valid clears and the state goes to IDLE.
  - A mismatching request in DONE clears hit-valid and is accepted as a new request (SETUP next).
  - No request in DONE: clear hit-valid, go to IDLE.
- inbus outside DONE/I/O holds the last data register value; it is never X after reset.
- stallX never depends combinationally on inputs.

Test Plan:
- Word write then read: wr adr=0x00100, outbus=0xDEADBEEF, WAIT_CYC=1 -> stallX high 4 cycles; SRAM sees [0x00080]=0xBEEF, [0x00081]=0xDEAD with we_n low one cycle each. rd same adr -> stallX high 4 cycles; on replay inbus=0xDEADBEEF, no extra SRAM cycle.
- Byte write/read: wr ben=1 adr=0x00103, outbus=0x5A -> one phase, sram_adr=0x00081, ub_n=0, lb_n=1, stallX high 2 cycles. rd ben=1 same adr -> inbus=0x0000005A.
- I/O pass-through: rd adr=0xFFFC4, io_din=0x12345678 -> io_sel=1, inbus=0x12345678 same cycle; stallX stays 0, sram_ce_n stays 1.
- WAIT_CYC=3 word read -> stallX high exactly 8 cycles; we_n stays 1 throughout; data captured only on the 3rd access cycle of each phase.
- Replay mismatch: in DONE present rd at a different adr -> no hit; new SETUP follows, stallX rises next cycle, and the old data is not returned.
- Reset mid-write: drop rst during ACCESS of phase 0 -> we_n/ce_n go high immediately, stallX=0. After release, state is IDLE and hit-valid=0, so a replay of the old request starts a fresh access.
